// File: rtl/game_pkg.sv
// Shared definitions for the game status controller: FSM states, display codes
// and BCD/binary conversion helpers used by the two-digit counters.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [3:0] MODE_IDLE   = 4'h0;
  localparam logic [3:0] MODE_PLAY   = 4'h1;
  localparam logic [3:0] MODE_OVER   = 4'h2;

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return 7'({3'b000, bcd[7:4]} * 7'd10 + {3'b000, bcd[3:0]});
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter (00..99) with load, +1, -1 and +5, all combinable in one
// cycle, saturating at both ends. value_nxt is exposed so the owner can register
// displays in step with the count.
module bcd_counter2
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       add5,
  output logic [7:0] value,
  output logic [7:0] value_nxt
);

  logic [8:0] acc;
  logic [6:0] sat;

  // Net step is -1..+6, so the sum never exceeds 105; bit 8 only sets on 0-1.
  always_comb begin
    acc = {2'b00, bcd_to_bin(value)}
        + (add5 ? 9'd5 : 9'd0)
        + (inc  ? 9'd1 : 9'd0)
        - (dec  ? 9'd1 : 9'd0);
    sat = 7'(acc);
    if (acc[8]) begin
      sat = 7'd0;
    end else if (acc > 9'd99) begin
      sat = 7'd99;
    end
    value_nxt = load ? load_val : bin_to_bcd(sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 8'h00;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/game_status_ctrl.sv
// Game status controller: countdown timer, score and lives with registered display
// holders. Define BONUS_TIME_EN to make each match add 5 seconds to the timer.
//
// state | meaning
// IDLE  | no game, displays blank
// PLAY  | game running, timer/score/lives live
// OVER  | game ended, final score shown
module game_status_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] TIME_START = 8'h60,
  parameter int         LIVES      = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       userquit,
  input  logic       match,
  input  logic       miss,
  input  logic       tick,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex2hldr,
  output logic [3:0] hex3hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  game_state_t state_q, state_nxt;
  logic        load, play, bonus;
  logic [7:0]  timer_q, timer_nxt, score_q, score_nxt;
  logic [3:0]  lives_q, lives_nxt;
  logic [9:0]  therm;

  assign play = (state_q == PLAY);
  assign load = start && !userquit && (state_q != PLAY);

`ifdef BONUS_TIME_EN
  assign bonus = play && match;
`else
  assign bonus = 1'b0;
`endif

  bcd_counter2 u_timer (
    .clk      (CLOCK_50),
    .reset    (reset),
    .load     (load),
    .load_val (TIME_START),
    .inc      (1'b0),
    .dec      (play && tick),
    .add5     (bonus),
    .value    (timer_q),
    .value_nxt(timer_nxt)
  );

  bcd_counter2 u_score (
    .clk      (CLOCK_50),
    .reset    (reset),
    .load     (load),
    .load_val (8'h00),
    .inc      (play && match),
    .dec      (1'b0),
    .add5     (1'b0),
    .value    (score_q),
    .value_nxt(score_nxt)
  );

  always_comb begin
    lives_nxt = lives_q;
    if (load) begin
      lives_nxt = 4'(LIVES);
    end else if (play && miss && lives_q != 4'd0) begin
      lives_nxt = lives_q - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (load) state_nxt = PLAY;
      PLAY: begin
        if (userquit || (tick && timer_nxt == 8'h00) || (miss && lives_nxt == 4'd0)) begin
          state_nxt = OVER;
        end
      end
      OVER: begin
        if (userquit) begin
          state_nxt = IDLE;
        end else if (load) begin
          state_nxt = PLAY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < 10; i++) begin
      therm[i] = (4'(i) < lives_nxt);
    end
  end

  // Displays are registered from next-state values so they move with the state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      lives_q  <= 4'd0;
      ingameOn <= 1'b0;
      gameOver <= 1'b0;
      hex0hldr <= MODE_IDLE;
      hex2hldr <= BLANK_DIGIT;
      hex3hldr <= BLANK_DIGIT;
      hex4hldr <= BLANK_DIGIT;
      hex5hldr <= BLANK_DIGIT;
      ledrhldr <= 10'd0;
    end else begin
      state_q  <= state_nxt;
      lives_q  <= lives_nxt;
      ingameOn <= 1'b0;
      gameOver <= 1'b0;
      hex0hldr <= MODE_IDLE;
      hex2hldr <= BLANK_DIGIT;
      hex3hldr <= BLANK_DIGIT;
      hex4hldr <= BLANK_DIGIT;
      hex5hldr <= BLANK_DIGIT;
      ledrhldr <= 10'd0;
      case (state_nxt)
        PLAY: begin
          ingameOn <= 1'b1;
          hex0hldr <= MODE_PLAY;
          hex2hldr <= timer_nxt[3:0];
          hex3hldr <= timer_nxt[7:4];
          hex4hldr <= score_nxt[3:0];
          hex5hldr <= score_nxt[7:4];
          ledrhldr <= therm;
        end
        OVER: begin
          gameOver <= 1'b1;
          hex0hldr <= MODE_OVER;
          hex4hldr <= score_nxt[3:0];
          hex5hldr <= score_nxt[7:4];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Self-checking bench for game_status_ctrl: a decimal reference model pushes the
// expected display word per cycle; each scenario pops and compares it.
module tb_game_status_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, start = 1'b0, userquit = 1'b0;
  logic       match = 1'b0, miss = 1'b0, tick = 1'b0;
  logic       ingameOn, gameOver;
  logic [3:0] hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr;
  logic [9:0] ledrhldr;

  game_status_ctrl #(.TIME_START(8'h60), .LIVES(10)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .userquit(userquit),
    .match(match), .miss(miss), .tick(tick),
    .ingameOn(ingameOn), .gameOver(gameOver), .hex0hldr(hex0hldr),
    .hex2hldr(hex2hldr), .hex3hldr(hex3hldr), .hex4hldr(hex4hldr),
    .hex5hldr(hex5hldr), .ledrhldr(ledrhldr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [5:0] R = 6'b100000, ST = 6'b010000, UQ = 6'b001000;
  localparam logic [5:0] MA = 6'b000100, MI = 6'b000010, TK = 6'b000001, NONE = 6'b000000;
  localparam logic [31:0] IDLE_WORD = {2'b00, 4'h0, 16'hFFFF, 10'h000};

`ifdef BONUS_TIME_EN
  localparam logic [7:0] EXP_T1 = 8'h63;
  localparam logic [7:0] EXP_T2 = 8'h99;
`else
  localparam logic [7:0] EXP_T1 = 8'h58;
  localparam logic [7:0] EXP_T2 = 8'h58;
`endif

  logic [31:0] obs, e;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  int m_state = 0, m_timer = 0, m_score = 0, m_lives = 0;

  assign obs = {ingameOn, gameOver, hex0hldr, hex3hldr, hex2hldr, hex5hldr, hex4hldr, ledrhldr};

  function automatic logic [31:0] model_out();
    case (m_state)
      1: return {1'b1, 1'b0, 4'h1, 4'(m_timer / 10), 4'(m_timer % 10),
                 4'(m_score / 10), 4'(m_score % 10), 10'((1 << m_lives) - 1)};
      2: return {1'b0, 1'b1, 4'h2, 8'hFF, 4'(m_score / 10), 4'(m_score % 10), 10'h000};
      default: return IDLE_WORD;
    endcase
  endfunction

  task automatic load_game();
    m_state = 1; m_timer = 60; m_score = 0; m_lives = 10;
  endtask

  task automatic model_step(input logic [5:0] v);
    int t;
    if (v[5]) begin
      m_state = 0; m_timer = 0; m_score = 0; m_lives = 0;
    end else begin
      case (m_state)
        0: if (v[4] && !v[3]) load_game();
        1: begin
          t = m_timer - (v[0] ? 1 : 0);
`ifdef BONUS_TIME_EN
          if (v[2]) t = t + 5;
`endif
          if (t > 99) t = 99;
          if (t < 0) t = 0;
          m_timer = t;
          if (v[2] && m_score < 99) m_score++;
          if (v[1] && m_lives > 0) m_lives--;
          if (v[3] || (v[0] && m_timer == 0) || (v[1] && m_lives == 0)) m_state = 2;
        end
        default: if (v[3]) m_state = 0; else if (v[4]) load_game();
      endcase
    end
  endtask

  task automatic drive(input logic [5:0] v);
    @(negedge CLOCK_50);
    {reset, start, userquit, match, miss, tick} = v;
    model_step(v);
    exp_q.push_back(model_out());
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] seq[4] = '{R, R | ST, ST | UQ, MA | MI | TK};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if (obs !== IDLE_WORD) begin errors++; $display("FAIL idle_word: got %h expected %h", obs, IDLE_WORD); end
  endtask

  task automatic test_start();
    drive(ST);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL start: got %h expected %h", obs, e); end
    checks++;
    if (obs !== {1'b1, 1'b0, 4'h1, 4'h6, 4'h0, 4'h0, 4'h0, 10'h3FF}) begin
      errors++; $display("FAIL start_word: got %h expected %h", obs, {1'b1, 1'b0, 4'h1, 4'h6, 4'h0, 4'h0, 4'h0, 10'h3FF});
    end
    drive(ST);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL start_in_play: got %h expected %h", obs, e); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 60; i++) begin
      drive(TK);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL tick[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if (gameOver !== 1'b1 || hex0hldr !== 4'h2 || {hex3hldr, hex2hldr} !== 8'hFF) begin
      errors++; $display("FAIL timeout_over: got %b/%h/%h expected 1/2/ff", gameOver, hex0hldr, {hex3hldr, hex2hldr});
    end
    drive(MA | MI | TK);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL over_ignore: got %h expected %h", obs, e); end
  endtask

  task automatic test_quit_priority();
    drive(ST | UQ);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL over_quit: got %h expected %h", obs, e); end
    checks++;
    if (obs !== IDLE_WORD) begin errors++; $display("FAIL over_quit_word: got %h expected %h", obs, IDLE_WORD); end
  endtask

  task automatic test_misses();
    drive(ST);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL miss_start: got %h expected %h", obs, e); end
    for (int i = 0; i < 10; i++) begin
      drive(MI);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL miss[%0d]: got %h expected %h", i, obs, e); end
      if (i < 9) begin
        checks++;
        if (ledrhldr !== (10'h3FF >> (i + 1))) begin
          errors++; $display("FAIL miss_ledr[%0d]: got %h expected %h", i, ledrhldr, 10'h3FF >> (i + 1));
        end
      end
    end
    checks++;
    if (gameOver !== 1'b1 || ledrhldr !== 10'h000) begin
      errors++; $display("FAIL miss_over: got %b/%h expected 1/000", gameOver, ledrhldr);
    end
  endtask

  task automatic test_matches();
    logic [5:0] pre[3] = '{ST, TK, TK | MA};
    for (int i = 0; i < 3; i++) begin
      drive(pre[i]);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL match_pre[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if ({hex3hldr, hex2hldr} !== EXP_T1) begin
      errors++; $display("FAIL tick_match_timer: got %h expected %h", {hex3hldr, hex2hldr}, EXP_T1);
    end
    for (int i = 0; i < 101; i++) begin
      drive(MA);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL match[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if ({hex5hldr, hex4hldr} !== 8'h99 || {hex3hldr, hex2hldr} !== EXP_T2) begin
      errors++; $display("FAIL match_sat: got %h/%h expected 99/%h", {hex5hldr, hex4hldr}, {hex3hldr, hex2hldr}, EXP_T2);
    end
  endtask

  task automatic test_match_quit();
    logic [5:0] seq[6] = '{UQ, ST, MA, MA, MA, MA | UQ};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL match_quit[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if (gameOver !== 1'b1 || {hex5hldr, hex4hldr} !== 8'h04) begin
      errors++; $display("FAIL match_quit_score: got %b/%h expected 1/04", gameOver, {hex5hldr, hex4hldr});
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] seq[4] = '{ST, TK | MA, MI, R | MA | TK};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, e); end
    end
    checks++;
    if (obs !== IDLE_WORD) begin errors++; $display("FAIL reset_mid_word: got %h expected %h", obs, IDLE_WORD); end
  endtask

  task automatic test_random();
    logic [5:0] v;
    for (int i = 0; i < 400; i++) begin
      v[5] = ($urandom_range(0, 199) == 0);
      v[4] = ($urandom_range(0, 99) < 8);
      v[3] = ($urandom_range(0, 99) < 2);
      v[2] = ($urandom_range(0, 99) < 30);
      v[1] = ($urandom_range(0, 99) < 8);
      v[0] = ($urandom_range(0, 99) < 40);
      drive(v);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_timeout();
    test_quit_priority();
    test_misses();
    test_matches();
    test_match_quit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
